io_display_unit: RTL and testbench

IO_DISPLAY_UNIT -- requirements
Module: io_display_unit

---
 rtl/io_pkg.sv | 15 +
 rtl/dabble_core.sv | 31 +++
 rtl/io_display_unit.sv | 131 +++++++++++++
 tb/tb_io_display_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared state encoding, segment table and BCD sizing for the display unit
package io_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic int bcd_bits(int w);
    return 4 * ((w * 30103 + 99999) / 100000);
  endfunction
  localparam int ITERS = 32;
  localparam int BCD_W = bcd_bits(ITERS);
endpackage

// File: rtl/dabble_core.sv
// dabble_core: shift/add-3 binary-to-BCD datapath, one step per strobe
module dabble_core
  import io_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BCD_W  = bcd_bits(WIDTH),
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  step,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out
);
  logic [BCD_W+WIDTH-1:0] sr_q, sr_d, adj;
  // add 3 to every BCD nibble >= 5, then shift the whole register left on a step
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < BCD_W / 4; i++)
      adj[WIDTH+4*i+:4] = sr_q[WIDTH+4*i+:4] >= 4'd5 ? sr_q[WIDTH+4*i+:4] + 4'd3 : sr_q[WIDTH+4*i+:4];
    sr_d = start ? {{BCD_W{1'b0}}, bin_in} : step ? adj << 1 : sr_q;
    bcd_out = '0;
    for (int i = 0; i < DIGITS; i++)
      if (i < BCD_W / 4) bcd_out[4*i+:4] = sr_q[WIDTH+4*i+:4];
  end
  // shift register holding {bcd, binary remainder}
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else sr_q <= sr_d;
endmodule

// File: rtl/io_display_unit.sv
// io_display_unit: CPU output register driving eight seven-segment digits in hex or decimal
module io_display_unit
  import io_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             dec_mode,
  output logic             busy,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5,
  output logic [6:0]       HEX6,
  output logic [6:0]       HEX7
);
  localparam int BW = bcd_bits(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] val_q, val_d, pval_q, pval_d, go_val;
  logic mode_q, mode_d, pend_q, pend_d, pmode_q, pmode_d, busy_q;
  logic go, go_mode, step, load;
  logic [4*DIGITS-1:0] bcd;
  logic [6:0] hex_q [8];
  logic [6:0] seg_d [8];
  logic [3:0] nib;
  dabble_core #(.WIDTH(WIDTH), .BCD_W(BW), .DIGITS(DIGITS)) u_dabble (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (go & go_mode),
    .step   (step),
    .bin_in (go_val),
    .bcd_out(bcd)
  );
  // next state; a write that cannot start now lands in the one-deep pending slot
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    val_d   = val_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    pmode_d = pmode_q;
    go      = 1'b0;
    go_val  = wdata;
    go_mode = dec_mode;
    step    = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: go = we;
      SHIFT: begin
        step    = 1'b1;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = LOAD;
        if (we) begin
          pend_d  = 1'b1;
          pval_d  = wdata;
          pmode_d = dec_mode;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = IDLE;
        go      = pend_q | we;
        if (pend_q) begin
          go_val  = pval_q;
          go_mode = pmode_q;
          pend_d  = we;
          pval_d  = wdata;
          pmode_d = dec_mode;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go) begin
      val_d   = go_val;
      mode_d  = go_mode;
      count_d = '0;
      state_d = go_mode ? SHIFT : LOAD;
    end
  end
  // segment decode of the finished value, digits beyond DIGITS show zero
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      nib = 4'd0;
      if (i < DIGITS) nib = mode_q ? bcd[4*i+:4] : val_q[4*i+:4];
      seg_d[i] = SEG[nib];
    end
  end
  // control, pending buffer and busy registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      val_q   <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      pmode_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      pmode_q <= pmode_d;
      busy_q  <= (state_d != IDLE) | pend_d;
    end
  // display registers, written only in LOAD
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 8; i++) hex_q[i] <= SEG[0];
    else if (load) hex_q <= seg_d;
  assign busy = busy_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];
endmodule

// File: tb/tb_io_display_unit.sv
// tb_io_display_unit: randomized and directed checks against a transaction-level display model
module tb_io_display_unit;
  logic clk = 1'b0, rst_n = 1'b1, we = 1'b0, dec_mode = 1'b0, busy;
  logic [31:0] wdata = '0;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  int checks = 0, errors = 0;
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  int m_rem, m_pv, m_cm, m_pm;
  logic [31:0] m_cd, m_pd;
  logic [55:0] m_hex;
  wire [55:0] hexv = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  always #5 clk = ~clk;
  io_display_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wdata   (wdata),
    .dec_mode(dec_mode),
    .busy    (busy),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3),
    .HEX4    (HEX4),
    .HEX5    (HEX5),
    .HEX6    (HEX6),
    .HEX7    (HEX7)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [55:0] pack_dig(input logic [31:0] d);
    logic [55:0] p;
    for (int i = 0; i < 8; i++) p[7*i+:7] = seg_tab[d[4*i+:4]];
    return p;
  endfunction
  function automatic logic [31:0] to_dig(input logic [31:0] v, input int m);
    logic [31:0] r = '0, x = v;
    if (m == 0) return v;
    for (int i = 0; i < 8; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  task automatic m_reset();
    m_rem = 0;
    m_pv = 0;
    m_hex = pack_dig(32'h0);
  endtask
  task automatic m_start(input logic [31:0] d, input int m);
    m_cd = d;
    m_cm = m;
    m_rem = m != 0 ? 33 : 1;
  endtask
  task automatic model_edge(input int w, input logic [31:0] d, input int m);
    if (m_rem == 0) begin
      if (w != 0) m_start(d, m);
    end else if (m_rem == 1) begin
      m_hex = pack_dig(to_dig(m_cd, m_cm));
      if (m_pv != 0) begin
        m_start(m_pd, m_pm);
        m_pv = w;
        m_pd = d;
        m_pm = m;
      end else if (w != 0) m_start(d, m);
      else m_rem = 0;
    end else begin
      m_rem--;
      if (w != 0) begin
        m_pv = 1;
        m_pd = d;
        m_pm = m;
      end
    end
  endtask
  task automatic tick(input int w, input logic [31:0] d, input int m);
    we = w != 0;
    wdata = d;
    dec_mode = m != 0;
    @(posedge clk);
    model_edge(w, d, m);
    @(negedge clk);
    we = 1'b0;
    chk("busy", busy, (m_rem != 0 || m_pv != 0) ? 1 : 0);
    chk("hex", hexv, m_hex);
  endtask
  task automatic pulse_rst();
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hex", hexv, pack_dig(32'h0));
    #1 rst_n = 1'b1;
  endtask
  initial begin
    int n;
    bit seen11, seen22;
    logic [31:0] d1, d2;
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    chk("init_busy", busy, 0);
    chk("init_hex", hexv, pack_dig(32'h0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 32'd123456, 1);
    n = busy;
    repeat (40) begin
      tick(0, 0, 0);
      n += busy;
    end
    chk("busy_len", n, 33);
    chk("dec123456", hexv, pack_dig(32'h00123456));
    tick(1, 32'hDEADBEEF, 0);
    tick(0, 0, 0);
    chk("hexDEADBEEF", hexv, pack_dig(32'hDEADBEEF));
    tick(1, 32'hFFFFFFFF, 1);
    repeat (34) tick(0, 0, 0);
    chk("decFFFFFFFF", hexv, pack_dig(32'h94967295));
    seen11 = 0;
    seen22 = 0;
    tick(1, 32'd11, 1);
    tick(1, 32'd22, 1);
    tick(1, 32'd33, 1);
    repeat (80) begin
      tick(0, 0, 0);
      if (hexv == pack_dig(32'h11)) seen11 = 1;
      if (hexv == pack_dig(32'h22)) seen22 = 1;
    end
    chk("saw11", seen11, 1);
    chk("no22", seen22, 0);
    chk("show33", hexv, pack_dig(32'h33));
    d1 = $urandom;
    d2 = $urandom;
    tick(1, d1, 1);
    n = 0;
    while (m_rem != 1 && n < 100) begin
      tick(0, 0, 0);
      n++;
    end
    tick(1, d2, 0);
    chk("load_first", hexv, pack_dig(to_dig(d1, 1)));
    tick(0, 0, 0);
    chk("load_second", hexv, pack_dig(d2));
    tick(1, 32'd99, 1);
    repeat (9) tick(0, 0, 0);
    pulse_rst();
    repeat (40) tick(0, 0, 0);
    chk("no_update", hexv, pack_dig(32'h0));
    repeat (600) begin
      tick($urandom_range(0, 5) == 0 ? 1 : 0,
           $urandom_range(0, 1) != 0 ? $urandom : $urandom_range(0, 999),
           $urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) pulse_rst();
    end
    repeat (40) tick(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
